eco32f_muldiv: RTL and testbench

Iterative multiply/divide/remainder sequencer for the eco32f execute stage. It accepts the decoded ex_op_mul/ex_op_div/ex_op_rem strobes with the two resolved operands. It runs a shared 32-step radix-2 shift-add / restoring-subtract datapath and holds the pipeline via muldiv_stall until the result is ready. Execute muxes muldiv_result onto its result bus in the cycle muldiv_done is high.

---
 rtl/eco32f_muldiv.sv | 161 ++++++++++++++++
 tb/tb_eco32f_muldiv.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/eco32f_muldiv.sv
// Iterative 32-step radix-2 multiply / divide / remainder sequencer for the execute stage.
// Latency: ITERATIONS+2 cycles from issue to done (1 cycle for divide-by-zero).
// Backpressure: muldiv_stall freezes ID/EX from the issue cycle until the cycle before done.
module eco32f_muldiv #(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_op_mul,
    input  logic        ex_op_div,
    input  logic        ex_op_rem,
    input  logic        ex_muldiv_signed,
    input  logic        ex_bubble,
    input  logic        ex_flush,
    input  logic [31:0] ex_opa,
    input  logic [31:0] ex_opb,
    output logic        muldiv_stall,
    output logic        muldiv_done,
    output logic [31:0] muldiv_result,
    output logic        muldiv_div_zero
);

    localparam int CW = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           op_mul;     // latched: multiply
    logic           op_rem;     // latched: remainder (divide when neither)
    logic           negate_q;   // product / quotient needs negation
    logic           negate_r;   // remainder needs negation
    logic           dz_pend;    // divide-by-zero flag for the DONE cycle
    logic [31:0]    a_reg;      // multiplicand (shifts left) or dividend->quotient
    logic [31:0]    b_reg;      // multiplier (shifts right) or divisor
    logic [31:0]    acc;        // low product or partial remainder
    logic [31:0]    result_q;

    // Issue-cycle decode and operand magnitudes.
    logic        start;
    logic        is_divlike;
    logic        opa_neg;
    logic        opb_neg;
    logic [31:0] opa_abs;
    logic [31:0] opb_abs;

    assign start      = (ex_op_mul | ex_op_div | ex_op_rem) & ~ex_bubble & ~ex_flush
                        & (state == S_IDLE);
    assign is_divlike = ex_op_div | ex_op_rem;
    assign opa_neg    = ex_muldiv_signed & ex_opa[31];
    assign opb_neg    = ex_muldiv_signed & ex_opb[31];
    assign opa_abs    = opa_neg ? (32'd0 - ex_opa) : ex_opa;
    assign opb_abs    = opb_neg ? (32'd0 - ex_opb) : ex_opb;

    // Stall is combinational so the pipeline freezes in the issue cycle itself.
    assign muldiv_stall    = ~ex_flush & (start | (state == S_BUSY) | (state == S_FIX));
    assign muldiv_done     = (state == S_DONE);
    assign muldiv_div_zero = (state == S_DONE) & dz_pend;
    assign muldiv_result   = result_q;

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        q_bit;
    logic [31:0] mul_acc_nxt;

    always_comb begin
        rem_sh      = {acc, a_reg[31]};
        rem_diff    = rem_sh - {1'b0, b_reg};
        q_bit       = ~rem_diff[32];
        mul_acc_nxt = b_reg[0] ? (acc + a_reg) : acc;
    end

    // Sign fix-up applied in the FIX state.
    logic [31:0] fix_val;

    always_comb begin
        fix_val = a_reg;
        if (op_mul) begin
            fix_val = negate_q ? (32'd0 - acc) : acc;
        end else if (op_rem) begin
            fix_val = negate_r ? (32'd0 - acc) : acc;
        end else begin
            fix_val = negate_q ? (32'd0 - a_reg) : a_reg;
        end
    end

    // Sequencer FSM and datapath registers; flush aborts from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_mul   <= 1'b0;
            op_rem   <= 1'b0;
            negate_q <= 1'b0;
            negate_r <= 1'b0;
            dz_pend  <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            result_q <= '0;
        end else if (ex_flush) begin
            state   <= S_IDLE;
            dz_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_mul   <= ex_op_mul;
                        op_rem   <= ~ex_op_mul & ex_op_rem;
                        negate_q <= ex_muldiv_signed & (ex_opa[31] ^ ex_opb[31]);
                        negate_r <= opa_neg;
                        a_reg    <= opa_abs;
                        b_reg    <= opb_abs;
                        acc      <= '0;
                        cnt      <= '0;
                        if (!ex_op_mul && is_divlike && (ex_opb == 32'd0)) begin
                            result_q <= '0;
                            dz_pend  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            dz_pend  <= 1'b0;
                            state    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (op_mul) begin
                        acc   <= mul_acc_nxt;
                        a_reg <= {a_reg[30:0], 1'b0};
                        b_reg <= {1'b0, b_reg[31:1]};
                    end else begin
                        acc   <= q_bit ? rem_diff[31:0] : rem_sh[31:0];
                        a_reg <= {a_reg[30:0], q_bit};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITERATIONS - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_val;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    dz_pend <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eco32f_muldiv.sv
// Directed self-checking bench for eco32f_muldiv.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every expected value below is hand-computed from the arithmetic definition.
module tb_eco32f_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_op_mul, ex_op_div, ex_op_rem, ex_muldiv_signed;
    logic        ex_bubble, ex_flush;
    logic [31:0] ex_opa, ex_opb;
    logic        muldiv_stall, muldiv_done, muldiv_div_zero;
    logic [31:0] muldiv_result;

    int tests  = 0;
    int failed = 0;

    eco32f_muldiv #(.ITERATIONS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_op_mul        (ex_op_mul),
        .ex_op_div        (ex_op_div),
        .ex_op_rem        (ex_op_rem),
        .ex_muldiv_signed (ex_muldiv_signed),
        .ex_bubble        (ex_bubble),
        .ex_flush         (ex_flush),
        .ex_opa           (ex_opa),
        .ex_opb           (ex_opb),
        .muldiv_stall     (muldiv_stall),
        .muldiv_done      (muldiv_done),
        .muldiv_result    (muldiv_result),
        .muldiv_div_zero  (muldiv_div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op at the current falling edge, follow it to done and check everything.
    task automatic run_op(input string tag, input logic m, input logic d, input logic r,
                          input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_dz, input int exp_stalls);
        int n;
        int stalls;
        ex_op_mul = m; ex_op_div = d; ex_op_rem = r; ex_muldiv_signed = sgn;
        ex_opa = a; ex_opb = b;
        n = 0;
        stalls = 0;
        #1;
        check({tag, "_issue_stall"}, {31'd0, muldiv_stall}, 32'd1);
        while (!muldiv_done && n < 100) begin
            if (muldiv_stall) stalls++;
            @(negedge clk);
            ex_op_mul = 1'b0; ex_op_div = 1'b0; ex_op_rem = 1'b0;
            ex_opa = 32'hDEAD_BEEF; ex_opb = 32'h1234_5678;
            n++;
            #1;
        end
        check({tag, "_done_seen"}, {31'd0, muldiv_done}, 32'd1);
        check({tag, "_stall_cycles"}, stalls, exp_stalls);
        check({tag, "_result"}, muldiv_result, exp_res);
        check({tag, "_div_zero"}, {31'd0, muldiv_div_zero}, {31'd0, exp_dz});
        check({tag, "_done_stall"}, {31'd0, muldiv_stall}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, muldiv_done}, 32'd0);
    endtask

    initial begin
        int dones;
        int stalls;
        rst = 1'b1;
        ex_op_mul = 1'b0; ex_op_div = 1'b0; ex_op_rem = 1'b0; ex_muldiv_signed = 1'b0;
        ex_bubble = 1'b0; ex_flush = 1'b0; ex_opa = '0; ex_opb = '0;
        repeat (2) @(negedge clk);
        check("rst_stall",  {31'd0, muldiv_stall}, 32'd0);
        check("rst_done",   {31'd0, muldiv_done}, 32'd0);
        check("rst_result", muldiv_result, 32'd0);
        check("rst_dz",     {31'd0, muldiv_div_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mulu",     1, 0, 0, 0, 32'h0001_0003, 32'h0000_0010, 32'h0010_0030, 0, 34);
        run_op("mul_neg",  1, 0, 0, 1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 0, 34);
        run_op("div_m7_2", 0, 1, 0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, 34);
        run_op("rem_m7_2", 0, 0, 1, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, 34);
        run_op("div_7_m2", 0, 1, 0, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 34);
        run_op("rem_7_m2", 0, 0, 1, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34);
        run_op("divu",     0, 1, 0, 0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 0, 34);
        run_op("remu",     0, 0, 1, 0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 0, 34);
        run_op("div_ovf",  0, 1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 34);
        run_op("rem_ovf",  0, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 34);
        run_op("div_zero", 0, 1, 0, 1, 32'h0000_0123, 32'h0000_0000, 32'h0000_0000, 1, 1);
        run_op("remu_zero",0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 1);

        // Flush abort: MUL issued at N, flush at N+10, new DIV at N+12.
        ex_op_mul = 1'b1; ex_muldiv_signed = 1'b0; ex_opa = 32'd9; ex_opb = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ex_op_mul = 1'b0;
        end
        ex_flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, muldiv_stall}, 32'd0);
        check("flush_done",  {31'd0, muldiv_done}, 32'd0);
        @(negedge clk);
        ex_flush = 1'b0;
        #1;
        check("flush_idle_stall", {31'd0, muldiv_stall}, 32'd0);
        check("flush_idle_done",  {31'd0, muldiv_done}, 32'd0);
        @(negedge clk);
        run_op("div_100_7", 0, 1, 0, 0, 32'd100, 32'd7, 32'd14, 0, 34);

        // Async reset mid-operation (result register currently holds 14).
        ex_op_mul = 1'b1; ex_opa = 32'd5; ex_opb = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ex_op_mul = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_stall",  {31'd0, muldiv_stall}, 32'd0);
        check("arst_done",   {31'd0, muldiv_done}, 32'd0);
        check("arst_result", muldiv_result, 32'd0);
        check("arst_dz",     {31'd0, muldiv_div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (muldiv_done) dones++;
        end
        check("arst_no_pulse", dones, 0);

        // Bubble with a divide strobe held: nothing must start.
        ex_op_div = 1'b1; ex_bubble = 1'b1; ex_opa = 32'd50; ex_opb = 32'd5;
        dones = 0;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (muldiv_done) dones++;
            if (muldiv_stall) stalls++;
            @(negedge clk);
        end
        check("bubble_stall", stalls, 0);
        check("bubble_done",  dones, 0);
        ex_op_div = 1'b0; ex_bubble = 1'b0;
        @(negedge clk);

        // Simultaneous flush and start: no start.
        ex_op_rem = 1'b1; ex_flush = 1'b1; ex_opa = 32'd50; ex_opb = 32'd7;
        @(negedge clk);
        ex_op_rem = 1'b0; ex_flush = 1'b0;
        #1;
        check("flush_start_stall", {31'd0, muldiv_stall}, 32'd0);
        check("flush_start_done",  {31'd0, muldiv_done}, 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
